// File: rtl/ws2812b_pkg.sv
// rtl/ws2812b_pkg.sv - shared types and pixel helpers for the WS2812B frame streamer
package ws2812b_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREFETCH = 2'd1,
    ST_SEND     = 2'd2,
    ST_LATCH    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ORDER_GRB = 2'd0,
    ORDER_RGB = 2'd1,
    ORDER_BGR = 2'd2
  } color_order_t;

  // brightness+1 keeps 255 as exact unity and 0 as full black
  function automatic logic [7:0] scale_channel(input logic [7:0] ch, input logic [7:0] bright);
    logic [15:0] prod;
    prod = {8'd0, ch} * ({8'd0, bright} + 16'd1);
    return prod[15:8];
  endfunction

  function automatic logic [23:0] pack_pixel(input color_order_t order, input logic [7:0] r,
                                             input logic [7:0] g, input logic [7:0] b);
    case (order)
      ORDER_RGB: return {r, g, b};
      ORDER_BGR: return {b, g, r};
      default:   return {g, r, b};
    endcase
  endfunction

endpackage

// File: rtl/ws2812b_bit_timer.sv
// rtl/ws2812b_bit_timer.sv - per-bit phase counter producing the registered WS2812B data level
module ws2812b_bit_timer #(
  parameter int BIT_CYCLES = 15,
  parameter int T0H_CYCLES = 4,
  parameter int T1H_CYCLES = 9
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run_i,
  input  logic                          bit_i,
  output logic [$clog2(BIT_CYCLES)-1:0] phase_o,
  output logic                          ws_o,
  output logic                          bit_end_o
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] T0H  = CW'(T0H_CYCLES);
  localparam logic [CW-1:0] T1H  = CW'(T1H_CYCLES);

  logic [CW-1:0] phase_q;
  logic          ws_q;

  // phase free-runs while sending so back-to-back bits share one period
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= '0;
      ws_q    <= 1'b0;
    end else begin
      ws_q <= run_i && (phase_q < (bit_i ? T1H : T0H));
      if (!run_i || phase_q == LAST) phase_q <= '0;
      else                           phase_q <= phase_q + CW'(1);
    end
  end

  assign phase_o   = phase_q;
  assign ws_o      = ws_q;
  assign bit_end_o = run_i && (phase_q == LAST);

endmodule

// File: rtl/ws2812b_frame_streamer.sv
// rtl/ws2812b_frame_streamer.sv - WS2812B chain driver: frame fetch, scaling, packing, sequencing
module ws2812b_frame_streamer
  import ws2812b_pkg::*;
#(
  parameter int NUM_PIXELS   = 64,
  parameter int NUM_FRAMES   = 32,
  parameter int BIT_CYCLES   = 15,
  parameter int T0H_CYCLES   = 4,
  parameter int T1H_CYCLES   = 9,
  parameter int LATCH_CYCLES = 3600,
  parameter int FRAME_REPEAT = 5,
  parameter int COLOR_ORDER  = 0,
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
  localparam int PW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [7:0]       brightness,
  output logic [FW+PW-1:0] rd_addr,
  input  logic [7:0]       rd_red,
  input  logic [7:0]       rd_green,
  input  logic [7:0]       rd_blue,
  output logic             ws_out,
  output logic [FW-1:0]    frame_idx,
  output logic             frame_done,
  output logic             busy
);

  localparam int PHW = $clog2(BIT_CYCLES);
  localparam int LW  = $clog2(LATCH_CYCLES);
  localparam int RW  = (FRAME_REPEAT > 1) ? $clog2(FRAME_REPEAT) : 1;
  localparam logic [FW-1:0]  LAST_FRAME = FW'(NUM_FRAMES - 1);
  localparam logic [PW-1:0]  LAST_PIXEL = PW'(NUM_PIXELS - 1);
  localparam logic [LW-1:0]  LATCH_LAST = LW'(LATCH_CYCLES - 1);
  localparam logic [LW-1:0]  LATCH_PRE  = LW'(LATCH_CYCLES - 2);
  localparam logic [PHW-1:0] CAPTURE_PH = PHW'(2);
  localparam color_order_t   ORDER      = color_order_t'(2'(COLOR_ORDER));

  state_t           state_q;
  logic             pf_q;
  logic             oneshot_q;
  logic [PW-1:0]    pixel_q;
  logic [4:0]       bit_idx_q;
  logic [LW-1:0]    latch_cnt_q;
  logic [RW-1:0]    repeat_q, next_repeat_d;
  logic [FW-1:0]    frame_q, next_frame_d;
  logic [FW+PW-1:0] rd_addr_q;
  logic [23:0]      shift_q, next_word_q, pixel_word_d;
  logic             frame_done_q;
  logic             last_repeat_d, oneshot_end_d, stop_d;
  logic [PHW-1:0]   phase;
  logic             bit_end;

  ws2812b_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES),
    .T0H_CYCLES(T0H_CYCLES),
    .T1H_CYCLES(T1H_CYCLES)
  ) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_i    (state_q == ST_SEND),
    .bit_i    (shift_q[23]),
    .phase_o  (phase),
    .ws_o     (ws_out),
    .bit_end_o(bit_end)
  );

  assign pixel_word_d = pack_pixel(ORDER, scale_channel(rd_red, brightness),
                                   scale_channel(rd_green, brightness),
                                   scale_channel(rd_blue, brightness));

  always_comb begin
    last_repeat_d = (int'(repeat_q) + 1) >= FRAME_REPEAT;
    next_repeat_d = repeat_q + RW'(1);
    next_frame_d  = frame_q;
    if (last_repeat_d) begin
      next_repeat_d = '0;
      case (mode)
        2'd0:    next_frame_d = (frame_q == LAST_FRAME) ? '0 : frame_q + FW'(1);
        2'd1:    if (frame_q != LAST_FRAME) next_frame_d = frame_q + FW'(1);
        default: next_frame_d = frame_q;
      endcase
    end
    oneshot_end_d = (mode == 2'd1) && (frame_q == LAST_FRAME) && last_repeat_d;
    stop_d        = !enable || oneshot_end_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pf_q         <= 1'b0;
      oneshot_q    <= 1'b0;
      pixel_q      <= '0;
      bit_idx_q    <= '0;
      latch_cnt_q  <= '0;
      repeat_q     <= '0;
      frame_q      <= '0;
      rd_addr_q    <= '0;
      shift_q      <= '0;
      next_word_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // a finished one-shot stays parked until enable drops or the mode changes
          if (!enable || mode != 2'd1) oneshot_q <= 1'b0;
          if (enable && !oneshot_q) begin
            rd_addr_q <= {frame_q, PW'(0)};
            pf_q      <= 1'b0;
            state_q   <= ST_PREFETCH;
          end
        end
        ST_PREFETCH: begin
          pf_q <= 1'b1;
          if (pf_q) begin
            next_word_q <= pixel_word_d;
            shift_q     <= pixel_word_d;
            bit_idx_q   <= 5'd23;
            pixel_q     <= '0;
            state_q     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (bit_idx_q == 5'd23 && pixel_q != LAST_PIXEL) begin
            if (phase == '0)        rd_addr_q   <= {frame_q, pixel_q + PW'(1)};
            if (phase == CAPTURE_PH) next_word_q <= pixel_word_d;
          end
          if (bit_end) begin
            if (bit_idx_q != 5'd0) begin
              bit_idx_q <= bit_idx_q - 5'd1;
              shift_q   <= {shift_q[22:0], 1'b0};
            end else if (pixel_q == LAST_PIXEL) begin
              latch_cnt_q <= '0;
              state_q     <= ST_LATCH;
            end else begin
              pixel_q   <= pixel_q + PW'(1);
              shift_q   <= next_word_q;
              bit_idx_q <= 5'd23;
            end
          end
        end
        ST_LATCH: begin
          latch_cnt_q <= latch_cnt_q + LW'(1);
          rd_addr_q   <= {next_frame_d, PW'(0)};
          if (latch_cnt_q == LATCH_PRE) frame_done_q <= 1'b1;
          if (latch_cnt_q == LATCH_LAST) begin
            latch_cnt_q <= '0;
            frame_q     <= next_frame_d;
            repeat_q    <= next_repeat_d;
            oneshot_q   <= enable && oneshot_end_d;
            if (stop_d) begin
              state_q <= ST_IDLE;
            end else begin
              shift_q     <= pixel_word_d;
              next_word_q <= pixel_word_d;
              bit_idx_q   <= 5'd23;
              pixel_q     <= '0;
              state_q     <= ST_SEND;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_addr    = rd_addr_q;
  assign frame_idx  = frame_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ws2812b_frame_streamer.sv
// tb/tb_ws2812b_frame_streamer.sv - self-checking bench for ws2812b_frame_streamer
module tb_ws2812b_frame_streamer;

  localparam int NP = 2;
  localparam int NF = 2;
  localparam int BC = 15;
  localparam int T0 = 4;
  localparam int T1 = 9;
  localparam int LC = 20;
  localparam int FR = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] brightness = 8'd255;
  logic [1:0] rd_addr;
  logic [7:0] rd_red = 8'd0, rd_green = 8'd0, rd_blue = 8'd0;
  logic       ws_out;
  logic [0:0] frame_idx;
  logic       frame_done;
  logic       busy;

  int total = 0;
  int bad = 0;

  logic [7:0] mem_r[NP*NF];
  logic [7:0] mem_g[NP*NF];
  logic [7:0] mem_b[NP*NF];

  int cyc = 0;
  int rises[$];
  int hi_len[$];
  int fd_frame[$];
  int fd_addr[$];
  logic ws_prev = 1'b0;
  int last_rise = 0;

  logic [47:0] dec_words[$];
  int hilen_err, space_err;
  int timed_out;
  int model_frame = 0;

  ws2812b_frame_streamer #(
    .NUM_PIXELS(NP), .NUM_FRAMES(NF), .BIT_CYCLES(BC), .T0H_CYCLES(T0),
    .T1H_CYCLES(T1), .LATCH_CYCLES(LC), .FRAME_REPEAT(FR), .COLOR_ORDER(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .brightness(brightness),
    .rd_addr(rd_addr), .rd_red(rd_red), .rd_green(rd_green), .rd_blue(rd_blue),
    .ws_out(ws_out), .frame_idx(frame_idx), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rd_red   <= mem_r[rd_addr];
    rd_green <= mem_g[rd_addr];
    rd_blue  <= mem_b[rd_addr];
  end

  always @(negedge clk) begin
    if (ws_out === 1'b1 && ws_prev == 1'b0) begin
      rises.push_back(cyc);
      last_rise = cyc;
    end
    if (ws_out === 1'b0 && ws_prev == 1'b1) hi_len.push_back(cyc - last_rise);
    ws_prev = (ws_out === 1'b1);
    if (frame_done === 1'b1) begin
      fd_frame.push_back(int'(frame_idx));
      fd_addr.push_back(int'(rd_addr));
    end
  end

  // reference: pixel 0 goes out first, each pixel as G,R,B bytes MSB first
  function automatic logic [47:0] frame_bits(input int f, input int b);
    logic [47:0] w;
    logic [7:0]  r8, g8, b8;
    w = '0;
    for (int p = 0; p < NP; p++) begin
      r8 = 8'((int'(mem_r[f*NP+p]) * (b + 1)) / 256);
      g8 = 8'((int'(mem_g[f*NP+p]) * (b + 1)) / 256);
      b8 = 8'((int'(mem_b[f*NP+p]) * (b + 1)) / 256);
      w = (w << 24) | {24'd0, g8, r8, b8};
    end
    return w;
  endfunction

  task automatic clear_mon();
    rises.delete();
    hi_len.delete();
    fd_frame.delete();
    fd_addr.delete();
  endtask

  task automatic decode();
    logic [47:0] cur;
    logic        bv;
    int          gap;
    dec_words.delete();
    hilen_err = 0;
    space_err = 0;
    cur = '0;
    for (int i = 0; i < rises.size(); i++) begin
      bv = 1'b0;
      if (i < hi_len.size()) begin
        if (hi_len[i] == T1) bv = 1'b1;
        else if (hi_len[i] != T0) hilen_err++;
      end else begin
        hilen_err++;
      end
      cur = {cur[46:0], bv};
      if (i % 48 == 47) dec_words.push_back(cur);
      if (i > 0) begin
        gap = (i % 48 == 0) ? BC + LC : BC;
        if (rises[i] - rises[i-1] != gap) space_err++;
      end
    end
  endtask

  task automatic fill_mem(input int red_first);
    for (int a = 0; a < NP*NF; a++) begin
      if (red_first != 0 && a % NP == 0) begin
        mem_r[a] = 8'hFF; mem_g[a] = 8'h00; mem_b[a] = 8'h00;
      end else begin
        mem_r[a] = 8'($urandom_range(0, 255));
        mem_g[a] = 8'($urandom_range(0, 255));
        mem_b[a] = 8'($urandom_range(0, 255));
      end
    end
  endtask

  // runs nfr frames, dropping enable part-way into the last one
  task automatic stream(input int nfr);
    int guard;
    timed_out = 0;
    clear_mon();
    enable = 1'b1;
    guard = 0;
    while (fd_frame.size() < nfr - 1 && guard < 3000 * nfr) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000 * nfr) timed_out = 1;
    repeat (50) @(negedge clk);
    enable = 1'b0;
    guard = 0;
    while (busy !== 1'b0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) timed_out = 1;
    repeat (5) @(negedge clk);
    decode();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (ws_out !== 1'b0) begin bad++; $display("FAIL rst_ws got=%b exp=0", ws_out); end
    total++; if (rd_addr !== 2'd0) begin bad++; $display("FAIL rst_addr got=%0d exp=0", rd_addr); end
    total++; if (frame_idx !== 1'b0) begin bad++; $display("FAIL rst_frame got=%0d exp=0", frame_idx); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", frame_done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (busy !== 1'b0 || ws_out !== 1'b0) begin
      bad++; $display("FAIL idle_hold busy=%b ws=%b exp=0,0", busy, ws_out);
    end
  endtask

  task automatic test_brightness();
    int bv;
    logic [47:0] expw;
    mode = 2'd0;
    for (int t = 0; t < 3; t++) begin
      bv = (t == 0) ? 255 : (t == 1) ? 127 : 0;
      brightness = 8'(bv);
      fill_mem(1);
      stream(1);
      expw = frame_bits(model_frame, bv);
      total++; if (timed_out != 0) begin bad++; $display("FAIL bright_timeout b=%0d got=1 exp=0", bv); end
      total++; if (rises.size() != 48) begin
        bad++; $display("FAIL bright_bits b=%0d got=%0d exp=48", bv, rises.size());
      end
      if (dec_words.size() > 0) begin
        total++; if (dec_words[0] !== expw) begin
          bad++; $display("FAIL bright_word b=%0d got=%h exp=%h", bv, dec_words[0], expw);
        end
      end
      total++; if (hilen_err != 0 || space_err != 0) begin
        bad++; $display("FAIL bright_timing b=%0d hi_err=%0d sp_err=%0d exp=0,0", bv, hilen_err, space_err);
      end
      total++; if (fd_frame.size() != 1 || (fd_frame.size() > 0 && fd_frame[0] != model_frame)) begin
        bad++; $display("FAIL bright_done b=%0d pulses=%0d exp=1 frame=%0d", bv, fd_frame.size(), model_frame);
      end
      model_frame = (model_frame + 1) % NF;
    end
  endtask

  task automatic test_loop();
    int bv, f;
    mode = 2'd0;
    bv = int'($urandom_range(0, 255));
    brightness = 8'(bv);
    fill_mem(0);
    stream(3);
    total++; if (timed_out != 0) begin bad++; $display("FAIL loop_timeout got=1 exp=0"); end
    total++; if (dec_words.size() != 3 || fd_frame.size() != 3) begin
      bad++; $display("FAIL loop_count words=%0d pulses=%0d exp=3,3", dec_words.size(), fd_frame.size());
    end
    total++; if (hilen_err != 0 || space_err != 0) begin
      bad++; $display("FAIL loop_timing hi_err=%0d sp_err=%0d exp=0,0", hilen_err, space_err);
    end
    for (int k = 0; k < 3; k++) begin
      f = (model_frame + k) % NF;
      if (k < dec_words.size()) begin
        total++; if (dec_words[k] !== frame_bits(f, bv)) begin
          bad++; $display("FAIL loop_word k=%0d got=%h exp=%h", k, dec_words[k], frame_bits(f, bv));
        end
      end
      if (k < fd_frame.size()) begin
        total++; if (fd_frame[k] != f || fd_addr[k] != ((f + 1) % NF) * NP) begin
          bad++; $display("FAIL loop_seq k=%0d frame=%0d addr=%0d exp=%0d,%0d",
                          k, fd_frame[k], fd_addr[k], f, ((f + 1) % NF) * NP);
        end
      end
    end
    model_frame = (model_frame + 3) % NF;
  endtask

  task automatic test_oneshot();
    int guard, nexp, bv;
    mode = 2'd1;
    bv = int'($urandom_range(0, 255));
    brightness = 8'(bv);
    fill_mem(0);
    clear_mon();
    nexp = NF - model_frame;
    enable = 1'b1;
    guard = 0;
    while (busy !== 1'b1 && guard < 10) begin @(negedge clk); guard++; end
    while (busy !== 1'b0 && guard < 3000 * NF) begin @(negedge clk); guard++; end
    total++; if (guard >= 3000 * NF) begin bad++; $display("FAIL oneshot_timeout got=1 exp=0"); end
    repeat (60) @(negedge clk);
    total++; if (busy !== 1'b0 || ws_out !== 1'b0) begin
      bad++; $display("FAIL oneshot_stop busy=%b ws=%b exp=0,0", busy, ws_out);
    end
    total++; if (frame_idx !== 1'(NF - 1)) begin
      bad++; $display("FAIL oneshot_frame got=%0d exp=%0d", frame_idx, NF - 1);
    end
    decode();
    total++; if (fd_frame.size() != nexp || dec_words.size() != nexp) begin
      bad++; $display("FAIL oneshot_count pulses=%0d words=%0d exp=%0d", fd_frame.size(), dec_words.size(), nexp);
    end
    for (int k = 0; k < nexp && k < dec_words.size(); k++) begin
      total++; if (dec_words[k] !== frame_bits(model_frame + k, bv)) begin
        bad++; $display("FAIL oneshot_word k=%0d got=%h exp=%h", k, dec_words[k], frame_bits(model_frame + k, bv));
      end
    end
    enable = 1'b0;
    repeat (3) @(negedge clk);
    model_frame = NF - 1;
  endtask

  task automatic test_hold();
    int bv;
    mode = 2'd2;
    bv = int'($urandom_range(0, 255));
    brightness = 8'(bv);
    fill_mem(0);
    stream(3);
    total++; if (timed_out != 0 || fd_frame.size() != 3) begin
      bad++; $display("FAIL hold_count timeout=%0d pulses=%0d exp=0,3", timed_out, fd_frame.size());
    end
    for (int k = 0; k < fd_frame.size(); k++) begin
      total++; if (fd_frame[k] != model_frame || fd_addr[k] != model_frame * NP) begin
        bad++; $display("FAIL hold_seq k=%0d frame=%0d addr=%0d exp=%0d,%0d",
                        k, fd_frame[k], fd_addr[k], model_frame, model_frame * NP);
      end
    end
    for (int k = 0; k < dec_words.size(); k++) begin
      total++; if (dec_words[k] !== frame_bits(model_frame, bv)) begin
        bad++; $display("FAIL hold_word k=%0d got=%h exp=%h", k, dec_words[k], frame_bits(model_frame, bv));
      end
    end
  endtask

  task automatic test_reset_midbit();
    int guard;
    mode = 2'd0;
    enable = 1'b1;
    guard = 0;
    repeat (40) @(negedge clk);
    while (ws_out !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    total++; if (ws_out !== 1'b1) begin bad++; $display("FAIL midbit_high got=%b exp=1", ws_out); end
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (ws_out !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      bad++; $display("FAIL midbit_rst ws=%b busy=%b done=%b exp=0,0,0", ws_out, busy, frame_done);
    end
    total++; if (rd_addr !== 2'd0 || frame_idx !== 1'b0) begin
      bad++; $display("FAIL midbit_regs addr=%0d frame=%0d exp=0,0", rd_addr, frame_idx);
    end
    enable = 1'b0;
    rst_n = 1'b1;
    model_frame = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    fill_mem(0);
    @(negedge clk);
    test_reset();
    test_brightness();
    test_loop();
    test_oneshot();
    test_hold();
    test_reset_midbit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
